// File: rtl/scripted_player_m.sv
`timescale 1ns/1ps
// scripted_player_m: replays a loadable move script onto the shared board bus,
// issuing one MOVE per player turn. The bus outputs float while the AI owns the turn.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------------
//  IDLE      | after reset, waiting for start
//  FETCH     | read entry[pointer]; skip NOP / illegal MOVE, stop on END
//  ARM       | command latched, waiting for the player to own the bus
//  SETUP     | location (and reset request) driven, submit low
//  PULSE     | submit high for SUBMIT_CYC cycles; pointer/turn_count advanced on entry
//  GAP       | submit and reset dropped for one cycle
//  WAIT_FLIP | MOVE issued, waiting for the turn to pass to the AI (with timeout)
//  DONE      | END reached or pointer wrapped; holds until start
module scripted_player_m #(
    parameter int BOARD_CELLS  = 9,
    parameter int IDX_W        = 4,
    parameter int SCRIPT_DEPTH = 16,
    parameter int SUBMIT_CYC   = 1,
    parameter int TURN_TIMEOUT = 64,
    localparam int AW          = $clog2(SCRIPT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             turn,
    input  logic             start,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [IDX_W+1:0] prog_data,
    output logic [IDX_W-1:0] update_loc,
    output logic             submit,
    output logic             reset,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AW:0]      turn_count
);

    localparam logic TURN_PLAYER = 1'b0;

    localparam logic [1:0] OP_MOVE  = 2'd0;
    localparam logic [1:0] OP_RESET = 2'd1;
    localparam logic [1:0] OP_NOP   = 2'd2;
    localparam logic [1:0] OP_END   = 2'd3;

    // One shared down-counter serves both the submit pulse and the flip timeout.
    localparam int TMAX = (SUBMIT_CYC > TURN_TIMEOUT) ? SUBMIT_CYC : TURN_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TMR_PULSE = TW'(SUBMIT_CYC - 1);
    localparam logic [TW-1:0] TMR_FLIP  = TW'(TURN_TIMEOUT - 1);

    localparam logic [IDX_W:0]  CELLS    = (IDX_W + 1)'(BOARD_CELLS);
    localparam logic [AW-1:0]   PTR_LAST = AW'(SCRIPT_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ARM,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_WAIT_FLIP,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W+1:0] mem [SCRIPT_DEPTH];

    logic [AW-1:0]    ptr, ptr_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [IDX_W-1:0] cur_loc_q, cur_loc_nxt;
    logic [IDX_W-1:0] loc_q, loc_nxt;
    logic             sub_q, sub_nxt;
    logic             rst_q, rst_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;
    logic [AW:0]      tc_q, tc_nxt;
    logic [TW-1:0]    tmr_q, tmr_nxt;
    logic             wrap_q, wrap_nxt;

    logic [IDX_W+1:0] entry;
    logic [1:0]       entry_op;
    logic [IDX_W-1:0] entry_loc;
    logic             entry_legal;
    logic             ptr_last;
    logic [AW-1:0]    ptr_adv;
    logic [AW:0]      tc_inc;
    logic             busy_int;

    assign entry       = mem[ptr];
    assign entry_op    = entry[IDX_W+1:IDX_W];
    assign entry_loc   = entry[IDX_W-1:0];
    assign entry_legal = ({1'b0, entry_loc} < CELLS);
    assign ptr_last    = (ptr == PTR_LAST);
    assign ptr_adv     = ptr_last ? '0 : ptr + 1'b1;
    assign tc_inc      = (&tc_q) ? tc_q : tc_q + 1'b1;
    assign busy_int    = (state != S_IDLE) && (state != S_DONE);

    // Script storage: no reset, writes only accepted while the player is idle.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_int) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            op_q      <= OP_NOP;
            cur_loc_q <= '0;
            loc_q     <= '0;
            sub_q     <= 1'b0;
            rst_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tc_q      <= '0;
            tmr_q     <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            op_q      <= op_nxt;
            cur_loc_q <= cur_loc_nxt;
            loc_q     <= loc_nxt;
            sub_q     <= sub_nxt;
            rst_q     <= rst_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            tc_q      <= tc_nxt;
            tmr_q     <= tmr_nxt;
            wrap_q    <= wrap_nxt;
        end
    end

    // Next-state and next-register values; start overrides everything.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        op_nxt      = op_q;
        cur_loc_nxt = cur_loc_q;
        loc_nxt     = loc_q;
        sub_nxt     = sub_q;
        rst_nxt     = rst_q;
        done_nxt    = done_q;
        err_nxt     = err_q;
        tc_nxt      = tc_q;
        tmr_nxt     = tmr_q;
        wrap_nxt    = wrap_q;

        case (state)
            S_FETCH: begin
                op_nxt      = entry_op;
                cur_loc_nxt = entry_loc;
                if (entry_op == OP_END) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else if ((entry_op == OP_NOP) ||
                             ((entry_op == OP_MOVE) && !entry_legal)) begin
                    if (entry_op == OP_MOVE) begin
                        err_nxt = 1'b1;
                    end
                    ptr_nxt = ptr_adv;
                    if (ptr_last) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    state_nxt = S_ARM;
                end
            end

            S_ARM: begin
                if (turn == TURN_PLAYER) begin
                    state_nxt = S_SETUP;
                    loc_nxt   = cur_loc_q;
                    rst_nxt   = (op_q == OP_RESET);
                    sub_nxt   = 1'b0;
                end
            end

            S_SETUP: begin
                // The command counts as issued even if the turn is lost here.
                ptr_nxt  = ptr_adv;
                wrap_nxt = ptr_last;
                if (op_q == OP_MOVE) begin
                    tc_nxt = tc_inc;
                end
                if (turn != TURN_PLAYER) begin
                    state_nxt = S_GAP;
                    sub_nxt   = 1'b0;
                    rst_nxt   = 1'b0;
                    tmr_nxt   = TMR_FLIP;
                end else begin
                    state_nxt = S_PULSE;
                    sub_nxt   = 1'b1;
                    tmr_nxt   = TMR_PULSE;
                end
            end

            S_PULSE: begin
                if ((turn != TURN_PLAYER) || (tmr_q == '0)) begin
                    state_nxt = S_GAP;
                    sub_nxt   = 1'b0;
                    rst_nxt   = 1'b0;
                    tmr_nxt   = TMR_FLIP;
                end else begin
                    tmr_nxt = tmr_q - 1'b1;
                end
            end

            S_GAP: begin
                // The flip timeout is measured from the cycle submit drops.
                if (op_q == OP_MOVE) begin
                    state_nxt = S_WAIT_FLIP;
                    tmr_nxt   = (tmr_q == '0) ? '0 : tmr_q - 1'b1;
                end else if (wrap_q) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = S_FETCH;
                end
            end

            S_WAIT_FLIP: begin
                if ((turn != TURN_PLAYER) || (tmr_q == '0)) begin
                    if (turn == TURN_PLAYER) begin
                        err_nxt = 1'b1;
                    end
                    if (wrap_q) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end else begin
                    tmr_nxt = tmr_q - 1'b1;
                end
            end

            default: begin
                state_nxt = state;
            end
        endcase

        if (start) begin
            state_nxt = S_FETCH;
            ptr_nxt   = '0;
            tc_nxt    = '0;
            err_nxt   = 1'b0;
            done_nxt  = 1'b0;
            sub_nxt   = 1'b0;
            rst_nxt   = 1'b0;
            wrap_nxt  = 1'b0;
        end
    end

    // Bus outputs float whenever the AI owns the turn.
    assign update_loc = (turn == TURN_PLAYER) ? loc_q : {IDX_W{1'bz}};
    assign submit     = (turn == TURN_PLAYER) ? sub_q : 1'bz;
    assign reset      = (turn == TURN_PLAYER) ? rst_q : 1'bz;

    assign busy       = busy_int;
    assign done       = done_q;
    assign err        = err_q;
    assign turn_count = tc_q;

endmodule

// File: tb/tb_scripted_player_m.sv
`timescale 1ns/1ps
// Testbench for scripted_player_m: scenario table plus directed corner sequences.
module tb_scripted_player_m;

    localparam int T = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       turn = 1'b0;
    logic       start = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [5:0] prog_data = '0;
    wire  [3:0] update_loc;
    wire        submit;
    wire        reset;
    logic       busy, done, err;
    logic [4:0] turn_count;

    // AI side of the shared bus, driven only while the AI owns the turn.
    logic [3:0] ai_loc = '0;
    logic       ai_submit = 1'b0;
    logic       ai_reset = 1'b0;
    assign update_loc = turn ? ai_loc : 4'bzzzz;
    assign submit     = turn ? ai_submit : 1'bz;
    assign reset      = turn ? ai_reset : 1'bz;

    scripted_player_m dut (
        .clk(clk), .rst_n(rst_n), .turn(turn), .start(start),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .update_loc(update_loc), .submit(submit), .reset(reset),
        .busy(busy), .done(done), .err(err), .turn_count(turn_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [5:0] mv(input int l);  return {2'd0, 4'(l)}; endfunction
    function automatic logic [5:0] rs(input int l);  return {2'd1, 4'(l)}; endfunction
    function automatic logic [5:0] nop();            return {2'd2, 4'd0};  endfunction
    function automatic logic [5:0] en();             return {2'd3, 4'd0};  endfunction

    typedef struct packed {
        logic [3:0][5:0] prog;
        logic [2:0]      n_exp;
        logic [2:0][4:0] exp_log;   // {reset, loc} per observed submit
        logic [4:0]      exp_tc;
        logic            exp_done;
        logic            exp_err;
    } scen_t;

    function automatic scen_t mk(input logic [5:0] e0, input logic [5:0] e1,
                                 input logic [5:0] e2, input logic [5:0] e3,
                                 input int n, input logic [4:0] l0, input logic [4:0] l1,
                                 input logic [4:0] l2, input int tc, input logic er);
        scen_t s;
        s.prog[0] = e0; s.prog[1] = e1; s.prog[2] = e2; s.prog[3] = e3;
        s.n_exp = 3'(n);
        s.exp_log[0] = l0; s.exp_log[1] = l1; s.exp_log[2] = l2;
        s.exp_tc = 5'(tc);
        s.exp_done = 1'b1;
        s.exp_err = er;
        return s;
    endfunction

    scen_t scen [6];

    task automatic load(input logic [3:0][5:0] prog);
        for (int i = 0; i < 4; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sub(input int lim, output int n);
        n = 0;
        while (!(turn == 1'b0 && submit == 1'b1) && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(input string name, input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(name, done, 1);
    endtask

    // Replays one table entry with an AI that takes the turn 2 cycles after each MOVE.
    task automatic run_scen(input int idx);
        scen_t s = scen[idx];
        logic [3:0][4:0] got = '0;
        int n = 0, flip = 0, hold = 0, cyc = 0;
        logic prev = 1'b0, now_sub;
        load(s.prog);
        pulse_start();
        while (!done && cyc < 400) begin
            now_sub = (turn == 1'b0) && (submit == 1'b1);
            if (now_sub && !prev) begin
                if (n < 4) got[n] = {reset, update_loc};
                n++;
                if (!reset) flip = 2;
            end else if (flip > 0) begin
                flip--;
                if (flip == 0) begin turn = 1'b1; hold = 3; end
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) turn = 1'b0;
            end
            prev = now_sub;
            @(negedge clk);
            cyc++;
        end
        turn = 1'b0;
        chk($sformatf("scen%0d finished", idx), done, s.exp_done);
        chk($sformatf("scen%0d submits", idx), n, s.n_exp);
        for (int i = 0; i < 3; i++)
            if (i < int'(s.n_exp))
                chk($sformatf("scen%0d cmd%0d", idx, i), got[i], s.exp_log[i]);
        chk($sformatf("scen%0d turn_count", idx), turn_count, s.exp_tc);
        chk($sformatf("scen%0d err", idx), err, s.exp_err);
        chk($sformatf("scen%0d busy", idx), busy, 0);
    endtask

    initial begin
        int n;

        scen[0] = mk(mv(0), mv(2), mv(5), en(), 3, 5'd0, 5'd2, 5'd5, 3, 1'b0);
        scen[1] = mk(mv(7), rs(0), mv(8), en(), 3, 5'd7, 5'd16, 5'd8, 2, 1'b0);
        scen[2] = mk(mv(12), mv(4), en(), en(), 1, 5'd4, 5'd0, 5'd0, 1, 1'b1);
        scen[3] = mk(nop(), mv(1), nop(), en(), 1, 5'd1, 5'd0, 5'd0, 1, 1'b0);
        scen[4] = mk(en(), en(), en(), en(), 0, 5'd0, 5'd0, 5'd0, 0, 1'b0);
        scen[5] = mk(mv(8), mv(9), en(), en(), 1, 5'd8, 5'd0, 5'd0, 1, 1'b1);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst turn_count", turn_count, 0);
        chk("rst submit", submit, 0);
        chk("rst reset", reset, 0);
        chk("rst update_loc", update_loc, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", busy, 0);

        for (int i = 0; i < 6; i++) run_scen(i);

        // Start-to-submit latency, then flip timeout and the next entry.
        load({en(), en(), mv(6), mv(3)});
        pulse_start();
        chk("lat busy", busy, 1);
        chk("lat submit c1", submit, 0);
        @(negedge clk);
        chk("lat submit c2", submit, 0);
        @(negedge clk);
        chk("lat submit c3", submit, 0);
        chk("lat setup loc", update_loc, 3);
        @(negedge clk);
        chk("lat submit c4", submit, 1);
        chk("lat loc", update_loc, 3);
        chk("lat turn_count", turn_count, 1);
        @(negedge clk);
        chk("gap submit", submit, 0);
        repeat (T - 1) @(negedge clk);
        chk("timeout err early", err, 0);
        @(negedge clk);
        chk("timeout err", err, 1);
        wait_sub(10, n);
        chk("post-timeout latency", n, 3);
        chk("post-timeout loc", update_loc, 6);
        chk("post-timeout turn_count", turn_count, 2);
        wait_done("timeout script done", 100);

        // AI holds the turn: bus shows the AI's values, FSM parks in ARM.
        ai_loc = 4'd3;
        turn = 1'b1;
        load({en(), en(), en(), mv(1)});
        pulse_start();
        repeat (10) @(negedge clk);
        chk("park busy", busy, 1);
        chk("park done", done, 0);
        chk("park bus loc", update_loc, 3);
        chk("park bus submit", submit, 0);
        ai_loc = 4'd0;
        turn = 1'b0;
        wait_sub(10, n);
        chk("park release latency", n, 2);
        chk("park release loc", update_loc, 1);
        wait_done("park script done", 100);

        // Turn lost mid-PULSE of a RESET: player must release the bus at once.
        load({en(), en(), en(), rs(5)});
        pulse_start();
        wait_sub(10, n);
        chk("rst-op submit", submit, 1);
        chk("rst-op reset", reset, 1);
        chk("rst-op loc", update_loc, 5);
        turn = 1'b1;
        #1;
        chk("release loc", update_loc, 0);
        chk("release submit", submit, 0);
        chk("release reset", reset, 0);
        @(negedge clk);
        turn = 1'b0;
        #1;
        chk("after loss submit", submit, 0);
        chk("after loss reset", reset, 0);
        wait_done("rst-op done", 20);
        chk("rst-op turn_count", turn_count, 0);

        // Async reset mid-PULSE, then replay from entry 0.
        load({en(), en(), en(), mv(2)});
        pulse_start();
        wait_sub(10, n);
        chk("pre-reset submit", submit, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async submit", submit, 0);
        chk("async busy", busy, 0);
        chk("async turn_count", turn_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_sub(10, n);
        chk("replay latency", n, 3);
        chk("replay loc", update_loc, 2);

        // Abort while waiting for a flip; the concurrent write is ignored while busy.
        repeat (5) @(negedge clk);
        chk("abort pre busy", busy, 1);
        chk("abort pre turn_count", turn_count, 1);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = mv(6);
        pulse_start();
        prog_we = 1'b0;
        chk("abort turn_count", turn_count, 0);
        chk("abort busy", busy, 1);
        chk("abort submit", submit, 0);
        wait_sub(10, n);
        chk("abort relaunch latency", n, 3);
        chk("abort write ignored", update_loc, 2);
        wait_done("abort done", 120);
        chk("abort timeout err", err, 1);

        // Write and start in the same cycle from DONE.
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = mv(6);
        pulse_start();
        prog_we = 1'b0;
        chk("we+start err cleared", err, 0);
        chk("we+start done cleared", done, 0);
        wait_sub(10, n);
        chk("we+start latency", n, 3);
        chk("we+start loc", update_loc, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
